// File: rtl/matmul_pkg.sv
// Shared types for the matmul address sequencer: FSM states, configuration record
// and default widths.
package matmul_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DIM_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIM_W_DEF-1:0]  dim_m;
    logic [DIM_W_DEF-1:0]  dim_n;
    logic [DIM_W_DEF-1:0]  dim_p;
    logic [ADDR_W_DEF-1:0] base_a;
    logic [ADDR_W_DEF-1:0] base_b;
    logic [ADDR_W_DEF-1:0] base_d;
  } cfg_t;

endpackage

// File: rtl/matmul_addr_seq_loop_counter.sv
// Wrapping loop counter: adds step on enable, returns to init once cnt+step reaches limit.
// Exposes the value it will hold after the next edge so callers can register derived outputs.
module loop_counter #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] init,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  logic [W-1:0] cnt;
  logic [W:0]   sum;

  // One extra bit so cnt+step never aliases below the limit.
  assign sum  = {1'b0, cnt} + {1'b0, step};
  assign wrap = (sum >= {1'b0, limit});

  always_comb begin
    nxt = cnt;
    if (load)    nxt = init;
    else if (en) nxt = wrap ? init : sum[W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= nxt;
  end

endmodule

// File: rtl/matmul_addr_seq.sv
// Walks the i/j/k loop nest of D = A x B for one core's interleaved rows and emits A/B/D
// addresses under valid/ready. Optional stall counter enabled by ADDR_SEQ_PERF_EN.
module matmul_addr_seq
  import matmul_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DIM_W     = DIM_W_DEF,
  parameter int NUM_CORES = 4,
  parameter int CORE_ID   = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_p,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_d,
  output logic              acc_first,
  output logic              acc_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cnt
);

  localparam int CW = DIM_W + 1;
  localparam logic [CW-1:0]     CID_C = CW'(CORE_ID);
  localparam logic [CW-1:0]     NC_C  = CW'(NUM_CORES);
  localparam logic [ADDR_W-1:0] CID_A = ADDR_W'(CORE_ID);
  localparam logic [ADDR_W-1:0] NC_A  = ADDR_W'(NUM_CORES);

  state_t            state;
  logic [CW-1:0]     m_q, n_q, p_q, n_cur;
  logic [ADDR_W-1:0] ba_q, bb_q, bd_q, ba, bb, bd;
  logic [ADDR_W-1:0] step_a, step_d, row_a, row_d, col_b, row_a_n, row_d_n, col_b_n;
  logic [CW-1:0]     k_n, j_n, i_n;
  logic              k_wrap, j_wrap, i_wrap;
  logic              load, adv, row_adv, fin_run, degen;

  assign load    = (state == IDLE) && start;
  assign adv     = addr_valid && addr_ready;
  assign row_adv = adv && k_wrap && j_wrap;
  assign fin_run = row_adv && i_wrap;
  // On load i_n is CORE_ID, so this also covers dim_m == 0.
  assign degen   = (dim_n == '0) || (dim_p == '0) || (i_n >= {1'b0, dim_m});

  loop_counter #(.W(CW)) u_k (
    .clock(clock), .reset_n(reset_n), .load(load), .en(adv),
    .init('0), .step(CW'(1)), .limit(n_q), .nxt(k_n), .wrap(k_wrap)
  );
  loop_counter #(.W(CW)) u_j (
    .clock(clock), .reset_n(reset_n), .load(load), .en(adv && k_wrap),
    .init('0), .step(CW'(1)), .limit(p_q), .nxt(j_n), .wrap(j_wrap)
  );
  loop_counter #(.W(CW)) u_i (
    .clock(clock), .reset_n(reset_n), .load(load), .en(row_adv),
    .init(CID_C), .step(NC_C), .limit(m_q), .nxt(i_n), .wrap(i_wrap)
  );

  assign n_cur = load ? {1'b0, dim_n} : n_q;
  assign ba    = load ? base_a : ba_q;
  assign bb    = load ? base_b : bb_q;
  assign bd    = load ? base_d : bd_q;

  // Row/column offsets advance incrementally; only constant products appear at load.
  always_comb begin
    row_a_n = row_a;
    row_d_n = row_d;
    col_b_n = col_b;
    if (load) begin
      row_a_n = CID_A * ADDR_W'(dim_n);
      row_d_n = CID_A * ADDR_W'(dim_p);
      col_b_n = '0;
    end else if (adv) begin
      col_b_n = k_wrap ? '0 : col_b + ADDR_W'(p_q);
      if (row_adv) begin
        row_a_n = row_a + step_a;
        row_d_n = row_d + step_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    row_a <= row_a_n;
    row_d <= row_d_n;
    col_b <= col_b_n;
    if (load) begin
      m_q    <= {1'b0, dim_m};
      n_q    <= {1'b0, dim_n};
      p_q    <= {1'b0, dim_p};
      ba_q   <= base_a;
      bb_q   <= base_b;
      bd_q   <= base_d;
      step_a <= NC_A * ADDR_W'(dim_n);
      step_d <= NC_A * ADDR_W'(dim_p);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      addr_d     <= '0;
      acc_first  <= 1'b0;
      acc_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load || (adv && !fin_run)) begin
        addr_a    <= ba + row_a_n + ADDR_W'(k_n);
        addr_b    <= bb + col_b_n + ADDR_W'(j_n);
        addr_d    <= bd + row_d_n + ADDR_W'(j_n);
        acc_first <= (k_n == '0);
        acc_last  <= ((k_n + CW'(1)) == n_cur);
      end
      case (state)
        IDLE: if (start) begin
          if (degen) begin
            state <= FIN;
          end else begin
            state      <= RUN;
            addr_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: if (fin_run) begin
          state      <= FIN;
          addr_valid <= 1'b0;
          busy       <= 1'b0;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDR_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      stall_cnt <= '0;
    else if (load)                     stall_cnt <= '0;
    else if (addr_valid && !addr_ready) stall_cnt <= sat_inc(stall_cnt);
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_matmul_addr_seq.sv
// Bench for matmul_addr_seq: two instances (1 core / core 1 of 4) checked against a
// loop-nest reference model, plus table vectors and hand sequences for reset abort.
module tb_matmul_addr_seq;
  import matmul_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        first;
    logic        last;
  } trip_t;

  typedef struct {
    cfg_t c;
    int   rmode;
    bit   seq1;
    int   exp0;
    int   exp1;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        addr_ready = 1'b0;
  logic [7:0]  dim_m = '0, dim_n = '0, dim_p = '0;
  logic [15:0] base_a = '0, base_b = '0, base_d = '0;
  logic        valid_o [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        first_o [2];
  logic        last_o  [2];
  logic [15:0] a_o [2];
  logic [15:0] b_o [2];
  logic [15:0] d_o [2];
  logic [31:0] stall_o [2];

  int checks = 0;
  int errors = 0;
  trip_t t1 [8];
  vec_t  tbl [7];
  vec_t  v;

  matmul_addr_seq #(.ADDR_W(16), .DIM_W(8), .NUM_CORES(1), .CORE_ID(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .dim_m(dim_m), .dim_n(dim_n), .dim_p(dim_p),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .addr_valid(valid_o[0]), .addr_ready(addr_ready),
    .addr_a(a_o[0]), .addr_b(b_o[0]), .addr_d(d_o[0]),
    .acc_first(first_o[0]), .acc_last(last_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .stall_cnt(stall_o[0])
  );

  matmul_addr_seq #(.ADDR_W(16), .DIM_W(8), .NUM_CORES(4), .CORE_ID(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .dim_m(dim_m), .dim_n(dim_n), .dim_p(dim_p),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .addr_valid(valid_o[1]), .addr_ready(addr_ready),
    .addr_a(a_o[1]), .addr_b(b_o[1]), .addr_d(d_o[1]),
    .acc_first(first_o[1]), .acc_last(last_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .stall_cnt(stall_o[1])
  );

  always #5 clock = ~clock;

  function automatic int nc_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int cid_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // Number of (i,j,k) steps this core owns.
  function automatic int total(input cfg_t c, input int nc, input int cid);
    int rows;
    if (c.dim_n == 0 || c.dim_p == 0 || cid >= int'(c.dim_m)) return 0;
    rows = (int'(c.dim_m) - cid + nc - 1) / nc;
    return rows * int'(c.dim_n) * int'(c.dim_p);
  endfunction

  // The t-th step of the nest: i outer (this core's rows), j middle, k inner.
  function automatic trip_t expect_trip(input cfg_t c, input int nc, input int cid, input int t);
    int n, p, per, i, j, k;
    trip_t e;
    n = int'(c.dim_n);
    p = int'(c.dim_p);
    per = n * p;
    i = cid + (t / per) * nc;
    j = (t % per) / n;
    k = t % n;
    e.a = c.base_a + 16'(i * n + k);
    e.b = c.base_b + 16'(k * p + j);
    e.d = c.base_d + 16'(i * p + j);
    e.first = (k == 0);
    e.last  = (k == n - 1);
    return e;
  endfunction

  function automatic vec_t mk(input int m, input int n, input int p, input int ba, input int bb,
                              input int bd, input int rmode, input bit seq1, input int e0,
                              input int e1);
    vec_t r;
    r.c.dim_m = 8'(m);
    r.c.dim_n = 8'(n);
    r.c.dim_p = 8'(p);
    r.c.base_a = 16'(ba);
    r.c.base_b = 16'(bb);
    r.c.base_d = 16'(bd);
    r.rmode = rmode;
    r.seq1 = seq1;
    r.exp0 = e0;
    r.exp1 = e1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // rmode: 0 ready always high, 1 random ready with restart attempt, 2 three-cycle stall at triple 2
  task automatic run_test(input vec_t vt);
    int tot [2];
    int idx [2];
    int nlast [2];
    int dn [2];
    int dcnt [2];
    int stl [2];
    int obs [2];
    int stall_left;
    bit fin;
    trip_t e, act;
    for (int d = 0; d < 2; d++) begin
      tot[d] = total(vt.c, nc_of(d), cid_of(d));
      idx[d] = 0;
      nlast[d] = (tot[d] == 0) ? 0 : -100;
      dn[d] = -1;
      dcnt[d] = 0;
      stl[d] = 0;
      obs[d] = 0;
    end
    stall_left = 3;
    fin = 1'b0;
    for (int n = 0; n < 3000 && !fin; n++) begin
      @(negedge clock);
      if (n == 0) begin
        dim_m = vt.c.dim_m; dim_n = vt.c.dim_n; dim_p = vt.c.dim_p;
        base_a = vt.c.base_a; base_b = vt.c.base_b; base_d = vt.c.base_d;
      end else if (n == 1 && vt.rmode == 1) begin
        dim_m = 8'($urandom); dim_n = 8'($urandom); dim_p = 8'($urandom);
        base_a = 16'($urandom); base_b = 16'($urandom); base_d = 16'($urandom);
      end
      start = (n == 0) || (vt.rmode == 1 && n == 3 && tot[0] >= 4 && tot[1] >= 4);
      case (vt.rmode)
        0: addr_ready = 1'b1;
        1: addr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (idx[0] == 2 && stall_left > 0) begin
            addr_ready = 1'b0;
            stall_left--;
          end else begin
            addr_ready = 1'b1;
          end
        end
      endcase
      for (int d = 0; d < 2; d++) begin
        act = {a_o[d], b_o[d], d_o[d], first_o[d], last_o[d]};
        if (valid_o[d] && addr_ready) begin
          if (vt.seq1 && d == 0 && obs[0] < 8) chk("t1_seq", 64'(act), 64'(t1[obs[0]]));
          obs[d]++;
        end
        if (n >= 1 && idx[d] < tot[d]) begin
          chk("valid_busy", 64'({valid_o[d], busy_o[d]}), 64'(2'b11));
          e = expect_trip(vt.c, nc_of(d), cid_of(d), idx[d]);
          chk("triple", 64'(act), 64'(e));
          if (!addr_ready) begin
            stl[d]++;
          end else begin
            idx[d]++;
            if (idx[d] == tot[d]) nlast[d] = n;
          end
        end else begin
          chk("idle_valid", 64'({valid_o[d], busy_o[d]}), 64'(2'b00));
        end
        if (done_o[d]) begin
          dcnt[d]++;
          if (dn[d] < 0) dn[d] = n;
        end
      end
      fin = (dn[0] >= 0) && (dn[1] >= 0) && (n >= dn[0] + 2) && (n >= dn[1] + 2);
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("done_cnt", 64'(dcnt[d]), 64'(1));
      chk("done_time", 64'(dn[d]), 64'(nlast[d] + 2));
      chk("xfer_cnt", 64'(obs[d]), 64'((d == 0) ? vt.exp0 : vt.exp1));
`ifdef ADDR_SEQ_PERF_EN
      chk("stall_cnt", 64'(stall_o[d]), 64'(stl[d]));
`else
      chk("stall_cnt", 64'(stall_o[d]), 64'(0));
`endif
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk(nm, 64'({valid_o[d], busy_o[d], done_o[d], first_o[d], last_o[d], a_o[d], b_o[d], d_o[d]}),
          64'(0));
      chk({nm, "_stall"}, 64'(stall_o[d]), 64'(0));
    end
  endtask

  initial begin
    t1[0] = {16'd0, 16'd16, 16'd32, 1'b1, 1'b0};
    t1[1] = {16'd1, 16'd18, 16'd32, 1'b0, 1'b1};
    t1[2] = {16'd0, 16'd17, 16'd33, 1'b1, 1'b0};
    t1[3] = {16'd1, 16'd19, 16'd33, 1'b0, 1'b1};
    t1[4] = {16'd2, 16'd16, 16'd34, 1'b1, 1'b0};
    t1[5] = {16'd3, 16'd18, 16'd34, 1'b0, 1'b1};
    t1[6] = {16'd2, 16'd17, 16'd35, 1'b1, 1'b0};
    t1[7] = {16'd3, 16'd19, 16'd35, 1'b0, 1'b1};
    //            M  N  P  base_a   b    d   rmode seq1 exp0 exp1
    tbl[0] = mk(2, 2, 2, 0,      16,  32,  0, 1'b1, 8,  4);
    tbl[1] = mk(6, 1, 1, 0,      0,   0,   0, 1'b0, 6,  2);
    tbl[2] = mk(2, 2, 2, 0,      16,  32,  2, 1'b1, 8,  4);
    tbl[3] = mk(2, 0, 2, 0,      16,  32,  0, 1'b0, 0,  0);
    tbl[4] = mk(1, 2, 2, 5,      6,   7,   0, 1'b0, 4,  0);
    tbl[5] = mk(1, 4, 1, 'hFFFE, 0,   0,   0, 1'b0, 4,  0);
    tbl[6] = mk(5, 3, 1, 100,    200, 300, 1, 1'b0, 15, 3);

    #1 reset_n = 1'b0;
    #1 chk_zero("reset_state");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int t = 0; t < 7; t++) run_test(tbl[t]);

    // Abort a run with reset, then confirm a fresh run starts from CORE_ID.
    @(negedge clock);
    dim_m = 8'd2; dim_n = 8'd2; dim_p = 8'd2;
    base_a = 16'd0; base_b = 16'd16; base_d = 16'd32;
    start = 1'b1;
    addr_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    chk("mid_run_valid", 64'({valid_o[0], valid_o[1]}), 64'(2'b11));
    reset_n = 1'b0;
    #1 chk_zero("reset_abort");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) chk("post_abort", 64'({valid_o[d], done_o[d]}), 64'(0));
    end
    run_test(tbl[0]);

    for (int r = 0; r < 6; r++) begin
      v = mk($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(1, 4),
             int'($urandom), int'($urandom), int'($urandom), 1, 1'b0, 0, 0);
      v.exp0 = total(v.c, 1, 0);
      v.exp1 = total(v.c, 4, 1);
      run_test(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
